dmem_hs: RTL and testbench

Parametrised, clocked, byte-addressable data memory for the multicycle core. It replaces the level-sensitive data memory with a valid/ready request–response interface and a configurable wait-state count. It adds sign-extended byte loads, alignment checking and range checking. It sits between the datapath's memory stage and the register-file write-back mux.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_array.sv | 49 ++++
 rtl/dmem_hs.sv | 146 ++++++++++++++
 tb/tb_dmem_hs.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked data memory.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic SZ_BYTE = 1'b0;
   localparam logic SZ_WORD = 1'b1;

   function automatic int bytes_of(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-organised storage with one word-wide read port and a per-byte write port.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 32,
   parameter int BYTES  = bytes_of(DATA_W)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [BYTES-1:0]  be,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int AW1   = ADDR_W + 1;
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [AW1-1:0] DEPTH_L = AW1'(DEPTH);

   logic [7:0]     mem [DEPTH];
   logic [AW1-1:0] baddr [BYTES];
   logic [BYTES-1:0] in_rng;
   logic [BYTES-1:0] wr_stb;

   // Lanes that fall past the end of the array never write and read as zero.
   always_comb begin
      baddr  = '{default: '0};
      in_rng = '0;
      wr_stb = '0;
      rdata  = '0;
      for (int i = 0; i < BYTES; i++) begin
         baddr[i]       = {1'b0, addr} + AW1'(i);
         in_rng[i]      = baddr[i] < DEPTH_L;
         wr_stb[i]      = we & be[i] & in_rng[i];
         rdata[8*i +: 8] = in_rng[i] ? mem[baddr[i][IDX_W-1:0]] : 8'h00;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < BYTES; i++) begin
         if (wr_stb[i]) begin
            mem[baddr[i][IDX_W-1:0]] <= wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/dmem_hs.sv
// Valid/ready data memory with configurable wait states, byte/word access,
// sign-extended byte loads and alignment/range checking.
//
// state | meaning
// IDLE  | ready for a request; access happens on acceptance when no wait states
// WAIT  | request latched; down-counter runs to its terminal count of zero
// RESP  | response held until the consumer takes it
module dmem_hs
   import dmem_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int DEPTH       = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic              req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int BYTES = bytes_of(DATA_W);
   localparam int AW1   = ADDR_W + 1;
   localparam logic [AW1-1:0] DEPTH_L = AW1'(DEPTH);
   localparam logic [AW1-1:0] BYTES_L = AW1'(BYTES);
   localparam logic [3:0]     WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   state_t state, state_nxt;
   logic [3:0] wait_cnt;

   logic              lat_we, lat_size, lat_signed;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;

   logic              cur_we, cur_size, cur_signed;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_wdata;

   logic              accept, do_access, acc_ok, arr_we;
   logic [AW1-1:0]    addr_ext;
   logic [BYTES-1:0]  be;
   logic [DATA_W-1:0] wr_data, rd_raw, load_data;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid) state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
         WAIT:    if (wait_cnt == 4'd0) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == IDLE);
      rsp_valid = (state == RESP);
   end

   // With no wait states the access uses the live request on the acceptance edge.
   always_comb begin
      accept     = (state == IDLE) && req_valid;
      do_access  = (state == IDLE) ? (req_valid && (WAIT_STATES == 0))
                                   : ((state == WAIT) && (wait_cnt == 4'd0));
      cur_we     = (state == IDLE) ? req_we     : lat_we;
      cur_size   = (state == IDLE) ? req_size   : lat_size;
      cur_signed = (state == IDLE) ? req_signed : lat_signed;
      cur_addr   = (state == IDLE) ? req_addr   : lat_addr;
      cur_wdata  = (state == IDLE) ? req_wdata  : lat_wdata;
   end

   always_comb begin
      addr_ext = {1'b0, cur_addr};
      if (cur_size == SZ_WORD) begin
         acc_ok  = ((addr_ext % BYTES_L) == '0) && ((addr_ext + BYTES_L) <= DEPTH_L);
         be      = '1;
         wr_data = cur_wdata;
      end else begin
         acc_ok  = addr_ext < DEPTH_L;
         be      = BYTES'(1);
         wr_data = {{(DATA_W-8){1'b0}}, cur_wdata[7:0]};
      end
      arr_we = do_access && cur_we && acc_ok && !reset;
   end

   dmem_array #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH),
      .BYTES (BYTES)
   ) u_array (
      .clk  (clk),
      .we   (arr_we),
      .be   (be),
      .addr (cur_addr),
      .wdata(wr_data),
      .rdata(rd_raw)
   );

   always_comb begin
      if (cur_size == SZ_WORD) load_data = rd_raw;
      else load_data = {{(DATA_W-8){cur_signed & rd_raw[7]}}, rd_raw[7:0]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt   <= 4'd0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         lat_we     <= 1'b0;
         lat_size   <= 1'b0;
         lat_signed <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
      end else begin
         if (accept) begin
            lat_we     <= req_we;
            lat_size   <= req_size;
            lat_signed <= req_signed;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            wait_cnt   <= WS_LOAD;
         end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if (do_access) begin
            rsp_rdata <= (acc_ok && !cur_we) ? load_data : '0;
            rsp_err   <= !acc_ok;
         end
      end
   end

endmodule

// File: tb/tb_dmem_hs.sv
// Scoreboard bench for dmem_hs: a 16-bit instance with wait states and a
// 32-bit zero-wait instance share one request bus, selected by sel.
module tb_dmem_hs;

   logic        clk = 1'b0;
   logic        reset;
   logic        sel;
   logic        req_valid, req_we, req_size, req_signed, rsp_ready;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;

   logic        a_req_ready, a_rsp_valid, a_rsp_err;
   logic [15:0] a_rsp_rdata;
   logic        b_req_ready, b_rsp_valid, b_rsp_err;
   logic [31:0] b_rsp_rdata;

   logic        o_req_ready, o_rsp_valid, o_rsp_err;
   logic [31:0] o_rsp_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  mem_m [2][32];
   logic [32:0] exp_q [$];
   string       tag_q [$];

   always #5 clk = ~clk;

   dmem_hs #(.DATA_W(16), .ADDR_W(16), .DEPTH(32), .WAIT_STATES(2)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
      .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata[15:0]),
      .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready & ~sel),
      .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
   );

   dmem_hs #(.DATA_W(32), .ADDR_W(16), .DEPTH(32), .WAIT_STATES(0)) u_dut32 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid & sel), .req_ready(b_req_ready),
      .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready & sel),
      .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
   );

   assign o_req_ready = sel ? b_req_ready : a_req_ready;
   assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
   assign o_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
   assign o_rsp_rdata = sel ? b_rsp_rdata : {16'h0000, a_rsp_rdata};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference behaviour: returns {err, rdata} and applies stores to the model.
   function automatic logic [32:0] model_access(input logic s, input logic we, input logic size,
                                                input logic sgn, input logic [15:0] addr,
                                                input logic [31:0] wdata);
      int          nb = s ? 4 : 2;
      int          a  = int'(addr);
      bit          ok;
      logic [31:0] r  = 32'h0;
      ok = size ? (((a % nb) == 0) && (a + nb <= 32)) : (a < 32);
      if (!ok) return {1'b1, 32'h0};
      if (we) begin
         if (size) for (int i = 0; i < nb; i++) mem_m[s][a+i] = wdata[8*i +: 8];
         else mem_m[s][a] = wdata[7:0];
         return {1'b0, 32'h0};
      end
      if (size) begin
         for (int i = 0; i < nb; i++) r[8*i +: 8] = mem_m[s][a+i];
      end else begin
         r[7:0] = mem_m[s][a];
         if (sgn && r[7]) r[31:8] = 24'hFFFFFF;
         if (!s) r[31:16] = 16'h0000;
      end
      return {1'b0, r};
   endfunction

   // mode 0: no model update, no response expected; 1: model + scoreboard; 2: model only
   task automatic issue(input string tag, input logic we, input logic size, input logic sgn,
                        input logic [15:0] addr, input logic [31:0] wdata, input int mode);
      logic [32:0] e;
      if (mode != 0) begin
         e = model_access(sel, we, size, sgn, addr, wdata);
         if (mode == 1) begin
            exp_q.push_back(e);
            tag_q.push_back(tag);
         end
      end
      req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_size   = 1'($urandom);
      req_signed = 1'($urandom);
      req_addr   = 16'($urandom);
      req_wdata  = $urandom;
   endtask

   task automatic wait_rsp(input int exp_lat, output logic [31:0] held);
      int          lat = 1;
      logic [32:0] e;
      string       t;
      while (!o_rsp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      held = e[31:0];
      check_eq({t, "_lat"},  32'(lat), 32'(exp_lat));
      check_eq({t, "_data"}, o_rsp_rdata, e[31:0]);
      check_eq({t, "_err"},  32'(o_rsp_err), 32'(e[32]));
   endtask

   task automatic finish_rsp(input string tag);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check_eq({tag, "_done_rv"},  32'(o_rsp_valid), 32'd0);
      check_eq({tag, "_done_rdy"}, 32'(o_req_ready), 32'd1);
   endtask

   task automatic xact(input string tag, input logic we, input logic size, input logic sgn,
                       input logic [15:0] addr, input logic [31:0] wdata, input int exp_lat);
      logic [31:0] held;
      issue(tag, we, size, sgn, addr, wdata, 1);
      wait_rsp(exp_lat, held);
      finish_rsp(tag);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_rdy"},   32'(o_req_ready), 32'd1);
      check_eq({tag, "_rv"},    32'(o_rsp_valid), 32'd0);
      check_eq({tag, "_rdata"}, o_rsp_rdata, 32'd0);
      check_eq({tag, "_err"},   32'(o_rsp_err), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] held;
      logic [32:0] e;
      for (int s = 0; s < 2; s++) for (int i = 0; i < 32; i++) mem_m[s][i] = 8'h00;
      sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 1'b0; req_signed = 1'b0;
      req_addr = 16'h0; req_wdata = 32'h0; rsp_ready = 1'b0; reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_reset_outputs("rst_a");

      // Preload the 16-bit instance with distinct words.
      for (int i = 0; i < 32; i += 2) xact("pre", 1'b1, 1'b1, 1'b0, 16'(i), 32'(16'h5A3C + i * 16'h0107), 3);

      // Word store/load and per-byte layout.
      xact("st4",  1'b1, 1'b1, 1'b0, 16'h0004, 32'h0000AAAA, 3);
      xact("ld4",  1'b0, 1'b1, 1'b0, 16'h0004, 32'h0, 3);
      xact("lb4",  1'b0, 1'b0, 1'b0, 16'h0004, 32'h0, 3);
      xact("lb5",  1'b0, 1'b0, 1'b0, 16'h0005, 32'h0, 3);

      // Byte store, signed/unsigned byte loads, neighbour byte untouched.
      xact("sb2",  1'b1, 1'b0, 1'b0, 16'h0002, 32'h0000FF81, 3);
      xact("lbs2", 1'b0, 1'b0, 1'b1, 16'h0002, 32'h0, 3);
      xact("lbu2", 1'b0, 1'b0, 1'b0, 16'h0002, 32'h0, 3);
      xact("lw2",  1'b0, 1'b1, 1'b1, 16'h0002, 32'h0, 3);

      // Alignment and range errors.
      xact("mis3",  1'b0, 1'b1, 1'b0, 16'h0003, 32'h0, 3);
      xact("st1f",  1'b1, 1'b1, 1'b0, 16'h001F, 32'h0000BEEF, 3);
      xact("lb1e",  1'b0, 1'b0, 1'b0, 16'h001E, 32'h0, 3);
      xact("lb1f",  1'b0, 1'b0, 1'b0, 16'h001F, 32'h0, 3);
      xact("lb20",  1'b0, 1'b0, 1'b0, 16'h0020, 32'h0, 3);
      xact("sb20",  1'b1, 1'b0, 1'b0, 16'h0020, 32'h000000EE, 3);
      xact("lw20",  1'b0, 1'b1, 1'b0, 16'h0020, 32'h0, 3);
      xact("lwffff",1'b0, 1'b1, 1'b0, 16'hFFFE, 32'h0, 3);
      xact("lw1e",  1'b0, 1'b1, 1'b0, 16'h001E, 32'h0, 3);

      // Back-pressure: response held while a new request waits.
      issue("hold_ld", 1'b0, 1'b1, 1'b0, 16'h0004, 32'h0, 1);
      wait_rsp(3, held);
      e = model_access(sel, 1'b0, 1'b0, 1'b1, 16'h0002, 32'h0);
      exp_q.push_back(e);
      tag_q.push_back("queued_lbs2");
      req_we = 1'b0; req_size = 1'b0; req_signed = 1'b1; req_addr = 16'h0002; req_wdata = 32'h0;
      req_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check_eq("hold_rv",   32'(o_rsp_valid), 32'd1);
         check_eq("hold_data", o_rsp_rdata, held);
         check_eq("hold_rdy",  32'(o_req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check_eq("hold_release_rv",  32'(o_rsp_valid), 32'd0);
      check_eq("hold_release_rdy", 32'(o_req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_eq("queued_accepted", 32'(o_req_ready), 32'd0);
      wait_rsp(3, held);
      finish_rsp("queued_lbs2");

      // Reset during WAIT abandons a store.
      issue("st8_abort", 1'b1, 1'b1, 1'b0, 16'h0008, 32'h00001234, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_reset_outputs("rst_wait");
      repeat (4) @(posedge clk);
      #1 check_eq("rst_wait_quiet", 32'(o_rsp_valid), 32'd0);
      xact("ld8", 1'b0, 1'b1, 1'b0, 16'h0008, 32'h0, 3);

      // Reset during RESP drops the response but keeps the committed store.
      issue("stA_drop", 1'b1, 1'b1, 1'b0, 16'h000A, 32'h00007E7E, 2);
      repeat (2) @(posedge clk);
      #1 check_eq("stA_in_resp", 32'(o_rsp_valid), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_reset_outputs("rst_resp");
      xact("ldA", 1'b0, 1'b1, 1'b0, 16'h000A, 32'h0, 3);

      // 32-bit instance, zero wait states.
      sel = 1'b1;
      #1 check_reset_outputs("rst_b");
      xact("b_st4",  1'b1, 1'b1, 1'b0, 16'h0004, 32'hAABBCCDD, 1);
      xact("b_ld4",  1'b0, 1'b1, 1'b0, 16'h0004, 32'h0, 1);
      xact("b_lb4",  1'b0, 1'b0, 1'b1, 16'h0004, 32'h0, 1);
      xact("b_lbs7", 1'b0, 1'b0, 1'b1, 16'h0007, 32'h0, 1);
      xact("b_lbu7", 1'b0, 1'b0, 1'b0, 16'h0007, 32'h0, 1);
      xact("b_sb5",  1'b1, 1'b0, 1'b0, 16'h0005, 32'h12345699, 1);
      xact("b_ld4b", 1'b0, 1'b1, 1'b0, 16'h0004, 32'h0, 1);
      xact("b_mis2", 1'b0, 1'b1, 1'b0, 16'h0002, 32'h0, 1);
      xact("b_st1c", 1'b1, 1'b1, 1'b0, 16'h001C, 32'h01020304, 1);
      xact("b_ld1c", 1'b0, 1'b1, 1'b0, 16'h001C, 32'h0, 1);
      xact("b_st20", 1'b1, 1'b1, 1'b0, 16'h0020, 32'hDEADBEEF, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
